// File: rtl/lmg_seq.sv
// lmg_seq -- sequencer between the legal-move generator (LMG) and the move
// consumer.
//
// A run restarts the LMG, then drains its 160-bit FIFO one word at a time.
// Each word is split into eight 19-bit move slots. Invalid slots are dropped,
// and valid moves are streamed out one at a time.
//
// Ports
//   clk, reset   clock; synchronous active-low reset
//   start        begin a run (only honoured in IDLE)
//   abort        cancel the current run, back to IDLE
//   lmg_rst      active-high reset to the LMG and its FIFO sclr
//   lmg_done     LMG has written all of its words
//   fifo_empty   LMG FIFO empty
//   fifo_rden    FIFO read request, one-cycle pulse
//   fifo_q       FIFO word {8'd0, slot0[151:133], ..., slot7[18:0]}
//   mv_valid     mv_data holds a valid move
//   mv_ready     consumer accepts mv_data this cycle
//   mv_data      move {flags[6:0], from[5:0], to[5:0]}
//   mv_cnt       valid moves emitted this run (saturates at 255)
//   busy         sequencer is not idle
//   done         one-cycle pulse at normal completion of a run
//   err_to       sticky WAIT timeout flag, cleared by the next accepted start
//   dbg_state    current FSM state, for debug and checkers
//
// Move handshake: a move transfers on any cycle where mv_valid and mv_ready
// are both high. Once mv_valid rises, it and mv_data stay constant until that
// transfer happens. The only exception is abort, which drops mv_valid on the
// next cycle. mv_valid and mv_data are decoded from registers only, so they
// never depend combinationally on mv_ready.
module lmg_seq #(
  parameter int RST_CYC = 2,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  output logic         lmg_rst,
  input  logic         lmg_done,
  input  logic         fifo_empty,
  output logic         fifo_rden,
  input  logic [159:0] fifo_q,
  output logic         mv_valid,
  input  logic         mv_ready,
  output logic [18:0]  mv_data,
  output logic [7:0]   mv_cnt,
  output logic         busy,
  output logic         done,
  output logic         err_to,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GRST = 3'd1,
    S_WAIT = 3'd2,
    S_RDWT = 3'd3,
    S_UNPK = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // One counter is shared by GRST (reset length), WAIT (timeout) and
  // RDWT (read latency). It must be wide enough for the largest of the three.
  localparam int CW = $clog2(TIMEOUT + RST_CYC + RD_LAT + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [151:0]    word_q, word_d;
  logic [7:0]      mv_cnt_q, mv_cnt_d;
  logic            err_q, err_d;
  logic            rden_q, rden_d;

  logic [18:0]     slot_a [8];
  logic [18:0]     slot;
  logic            slot_ok;
  logic            unused_pad;

  // The top byte of every FIFO word is padding.
  assign unused_pad = ^fifo_q[159:152];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      slot_a[i] = word_q[151 - 19*i -: 19];
    end
  end

  assign slot    = slot_a[idx_q];
  assign slot_ok = ~slot[18];   // flags[6] marks an empty slot

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    mv_cnt_d = mv_cnt_q;
    err_d    = err_q;
    rden_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_GRST;
          cnt_d    = '0;
          mv_cnt_d = '0;
          err_d    = 1'b0;
        end
      end
      S_GRST: begin
        if (cnt_q == CW'(RST_CYC - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (!fifo_empty) begin
          // The read pulse is registered, so it is issued in the first
          // RDWT cycle.
          rden_d  = 1'b1;
          state_d = S_RDWT;
          cnt_d   = '0;
        end else if (lmg_done) begin
          state_d = S_FIN;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RDWT: begin
        // cnt 0 is the read-request cycle. The word is valid RD_LAT cycles
        // later.
        if (cnt_q == CW'(RD_LAT)) begin
          word_d  = fifo_q[151:0];
          idx_d   = '0;
          state_d = S_UNPK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_UNPK: begin
        if (!slot_ok || mv_ready) begin
          if (slot_ok && (mv_cnt_q != 8'hff)) begin
            mv_cnt_d = mv_cnt_q + 8'd1;
          end
          if (idx_q == 3'd7) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE. The move count and the
    // timeout flag keep their values, and a pending move is not counted.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      mv_cnt_d = mv_cnt_q;
      err_d    = err_q;
      rden_d   = 1'b0;
      word_d   = word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      mv_cnt_q <= '0;
      err_q    <= 1'b0;
      rden_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      mv_cnt_q <= mv_cnt_d;
      err_q    <= err_d;
      rden_q   <= rden_d;
    end
  end

  assign lmg_rst   = (state_q == S_IDLE) || (state_q == S_GRST);
  assign fifo_rden = rden_q;
  assign mv_valid  = (state_q == S_UNPK) && slot_ok;
  assign mv_data   = mv_valid ? slot : 19'd0;
  assign mv_cnt    = mv_cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign err_to    = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lmg_seq.sv
// tb_lmg_seq -- directed bench for lmg_seq.
// Includes a dummy LMG with its FIFO, a move scoreboard, and checks of the
// move count on every cycle.
module tb_lmg_seq;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic         lmg_rst, lmg_done, fifo_empty, fifo_rden;
  logic [159:0] fifo_q;
  logic         mv_valid, mv_ready;
  logic [18:0]  mv_data;
  logic [7:0]   mv_cnt;
  logic         busy, done, err_to;
  logic [2:0]   unused_dbg;

  localparam logic [159:0] GARB = {8'd0, {8{19'h12345}}};

  always #5 clk = ~clk;

  lmg_seq #(.RST_CYC(2), .RD_LAT(1), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lmg_rst(lmg_rst), .lmg_done(lmg_done), .fifo_empty(fifo_empty),
    .fifo_rden(fifo_rden), .fifo_q(fifo_q), .mv_valid(mv_valid),
    .mv_ready(mv_ready), .mv_data(mv_data), .mv_cnt(mv_cnt), .busy(busy),
    .done(done), .err_to(err_to), .dbg_state(unused_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [18:0] mk(input int fl, input int fr, input int to);
    return {7'(fl), 6'(fr), 6'(to)};
  endfunction

  function automatic logic [18:0] slot_of(input int kind, input int i, input int base);
    case (kind)
      1: return mk(0, i + 1, i + 2);                                   // DMV1
      2: return mk(1, 8 + i, 16 + i);                                  // DMV2
      3: return (i < 4) ? mk(0, 45 + i, 55 + i) : mk(7'h40 + i, i, i); // DMV3
      4: return mk(7'h7f, i, 63 - i);                                  // all invalid
      5: return (i % 2 == 1) ? mk(7'h41, i, i) : mk(7'h3f, 20 + i, 40 + i);
      default: return mk(2, i, base % 64);
    endcase
  endfunction

  logic [159:0] script[$];
  logic [18:0]  exp_q[$];
  logic [18:0]  log_q[$];
  bit           en_done = 1'b1;

  task automatic clear_script();
    script.delete();
    exp_q.delete();
    log_q.delete();
  endtask

  // Words follow the FIFO layout. Slot i sits 19*(7-i) bits up from bit 0.
  task automatic add_word(input int kind, input int base);
    logic [159:0] w;
    logic [18:0]  s;
    w = '0;
    for (int i = 0; i < 8; i++) w = w | (160'(slot_of(kind, i, base)) << (19 * (7 - i)));
    script.push_back(w);
    for (int i = 0; i < 8; i++) begin
      s = 19'(w >> (19 * (7 - i)));
      if (s[18] == 1'b0) exp_q.push_back(s);
    end
  endtask

  // ---------------- dummy LMG + FIFO ----------------
  // Updated on the falling edge. One word is pushed every 3 cycles while
  // lmg_rst is low. Read data appears one cycle after the request cycle;
  // at all other times fifo_q carries garbage.
  logic [159:0] fifo_m[$];
  logic [159:0] pend;
  bit           have_pend;
  int           gen_pos, gap;

  initial begin
    lmg_done = 1'b0; fifo_empty = 1'b1; fifo_q = GARB;
    have_pend = 0; gen_pos = 0; gap = 0; pend = '0;
  end

  always @(negedge clk) begin
    if (lmg_rst === 1'b1) begin
      fifo_m.delete();
      gen_pos = 0; gap = 0; have_pend = 0;
      lmg_done = 1'b0;
      fifo_q = GARB;
    end else begin
      fifo_q = have_pend ? pend : GARB;
      have_pend = 0;
      if (fifo_rden === 1'b1) begin
        check("rd_nonempty", (fifo_m.size() > 0), 1);
        if (fifo_m.size() > 0) begin
          pend = fifo_m.pop_front();
          have_pend = 1;
        end
      end
      if (gen_pos < script.size()) begin
        gap++;
        if (gap == 3) begin
          fifo_m.push_back(script[gen_pos]);
          gen_pos++;
          gap = 0;
        end
      end else begin
        lmg_done = en_done;
      end
    end
    fifo_empty = (fifo_m.size() == 0);
  end

  // ---------------- consumer ready driver ----------------
  int ready_mode = 0;
  int rcyc = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       mv_ready = (rcyc % 3 == 0);
      2:       mv_ready = (log_q.size() < 12);
      default: mv_ready = 1'b1;
    endcase
    rcyc++;
  end

  // ---------------- compare process ----------------
  bit          chk_en = 0;
  bit          accept_start = 0;
  int          cnt_m = 0;
  int          done_cnt = 0;
  bit          prev_stall = 0;
  logic [18:0] prev_data = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mv_cnt", mv_cnt, cnt_m);
      if (prev_stall) begin
        check("stall_valid", mv_valid, 1);
        check("stall_data", mv_data, prev_data);
      end
      if (mv_valid && mv_ready && !abort) begin
        check("move_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("mv_data", mv_data, exp_q.pop_front());
        log_q.push_back(mv_data);
        if (cnt_m < 255) cnt_m++;
      end
      if (done) begin
        done_cnt++;
        check("drained_at_done", exp_q.size(), 0);
      end
      if (start && accept_start) cnt_m = 0;
      prev_stall = mv_valid && !mv_ready && !abort;
      prev_data  = mv_data;
    end
  end

  // ---------------- clock/reset and sequence ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit acc);
    start = 1'b1;
    accept_start = acc;
    tick();
    start = 1'b0;
    accept_start = 0;
  endtask

  task automatic wait_done(input int budget);
    int  d0;
    bit  ok;
    d0 = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > d0) begin
        ok = 1;
        break;
      end
    end
    check("done_seen", ok, 1);
  endtask

  task automatic std_script();
    clear_script();
    add_word(1, 0);
    add_word(2, 0);
    add_word(3, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    bit ok;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mv_ready = 1'b1;

    // 1. reset
    tick(); tick();
    reset = 1'b1;
    check("rst_lmg_rst", lmg_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_mv_valid", mv_valid, 0);
    check("rst_mv_data", mv_data, 0);
    check("rst_mv_cnt", mv_cnt, 0);
    check("rst_done", done, 0);
    check("rst_err_to", err_to, 0);
    check("rst_fifo_rden", fifo_rden, 0);
    chk_en = 1;
    tick();

    // 2. full run with the consumer always ready
    std_script();
    ready_mode = 0;
    d0 = done_cnt;
    do_start(1);
    wait_done(600);
    check("t2_count", log_q.size(), 20);
    check("t2_first", log_q[0], 19'h00042);
    check("t2_last", log_q[19], 19'h00C3A);
    check("t2_mv_cnt", mv_cnt, 20);
    repeat (3) tick();
    check("t2_one_done", done_cnt - d0, 1);

    // 3. consumer ready on one cycle in three
    std_script();
    ready_mode = 1;
    do_start(1);
    wait_done(1500);
    check("t3_count", log_q.size(), 20);
    check("t3_last", log_q[19], 19'h00C3A);
    check("t3_mv_cnt", mv_cnt, 20);

    // 4. abort while the 5th move of DMV2 is stalled
    std_script();
    ready_mode = 2;
    d0 = done_cnt;
    do_start(1);
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (log_q.size() == 12 && mv_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("t4_reach_13th", ok, 1);
    tick();
    check("t4_held_valid", mv_valid, 1);
    check("t4_held_data", mv_data, 19'h01314);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid_drop", mv_valid, 0);
    check("t4_idle", busy, 0);
    check("t4_mv_cnt", mv_cnt, 12);
    repeat (20) tick();
    check("t4_no_done", done_cnt - d0, 0);
    std_script();
    ready_mode = 0;
    do_start(1);
    wait_done(600);
    check("t4_rerun_count", log_q.size(), 20);
    check("t4_rerun_cnt", mv_cnt, 20);

    // 5. timeout: FIFO stays empty and lmg_done stays low
    clear_script();
    en_done = 1'b0;
    d0 = done_cnt;
    do_start(1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("t5_busy_cycles", n, 18);
    check("t5_err_to", err_to, 1);
    check("t5_no_done", done_cnt - d0, 0);
    en_done = 1'b1;
    do_start(1);
    check("t5_err_clear", err_to, 0);
    wait_done(100);
    check("t5_empty_run_cnt", mv_cnt, 0);

    // 6. a start pulse during a run is ignored
    std_script();
    d0 = done_cnt;
    do_start(1);
    repeat (15) tick();
    do_start(0);
    wait_done(600);
    repeat (5) tick();
    check("t6_mv_cnt", mv_cnt, 20);
    check("t6_one_done", done_cnt - d0, 1);

    // 7. words with all slots invalid and with mixed slots
    clear_script();
    add_word(4, 0);
    add_word(5, 0);
    add_word(4, 0);
    add_word(3, 0);
    do_start(1);
    wait_done(600);
    check("t7_mv_cnt", mv_cnt, 8);
    check("t7_first", log_q[0], 19'h3F528);

    // 8. move count saturates at 255
    clear_script();
    for (int k = 0; k < 33; k++) add_word(6, k);
    do_start(1);
    wait_done(3000);
    check("t8_moves", log_q.size(), 264);
    check("t8_mv_cnt_sat", mv_cnt, 255);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
